// File: rtl/tx_axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO feeding the MAC TX path.
// A frame is released to the m-side only once its tlast beat is stored; frames that overflow are dropped whole.
module tx_axis_frame_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  mac_clk,
    input  logic                  mac_rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   frame_count,
    output logic                  drop_pulse,
    output logic [31:0]           stat_drop_count
);

    localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {NORMAL, DROPPING} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     wr_commit_q, wr_commit_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     frame_count_q, frame_count_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
    logic                    m_tlast_q, m_tlast_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    drop_pulse_q, drop_pulse_d;
    logic [31:0]             stat_drop_q, stat_drop_d;
    logic                    ready_q;

    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [ENTRY_W-1:0]      rd_entry;
    logic                    s_accept, full, ram_we, commit, avail, load, take;

    // Full compares against the current rd_ptr only; a same-cycle read does not free a slot early.
    always_comb begin
        s_accept      = s_axis_tvalid & ready_q;
        full          = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        wr_commit_d   = wr_commit_q;
        drop_pulse_d  = 1'b0;
        stat_drop_d   = stat_drop_q;
        ram_we        = 1'b0;
        commit        = 1'b0;
        if (s_accept) begin
            case (state_q)
                NORMAL: begin
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_axis_tlast) begin
                            wr_commit_d = wr_ptr_q + 1'b1;
                            commit      = 1'b1;
                        end
                    end else begin
                        wr_ptr_d     = wr_commit_q;
                        drop_pulse_d = 1'b1;
                        stat_drop_d  = stat_drop_q + 32'd1;
                        if (!s_axis_tlast) state_d = DROPPING;
                    end
                end
                DROPPING: begin
                    if (s_axis_tlast) state_d = NORMAL;
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    // Output register: reload whenever it is empty or being drained and committed data exists.
    always_comb begin
        rd_entry   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        avail      = rd_ptr_q != wr_commit_q;
        take       = m_tvalid_q & m_axis_tready;
        load       = (!m_tvalid_q | m_axis_tready) & avail;
        rd_ptr_d   = rd_ptr_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (load) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            m_tvalid_d = 1'b1;
            {m_tlast_d, m_tkeep_d, m_tdata_d} = rd_entry;
        end else if (take) begin
            m_tvalid_d = 1'b0;
        end
        frame_count_d = frame_count_q;
        if (commit && !(take && m_tlast_q))
            frame_count_d = frame_count_q + 1'b1;
        else if (!commit && take && m_tlast_q)
            frame_count_d = frame_count_q - 1'b1;
    end

    always_ff @(posedge mac_clk) begin
        if (ram_we)
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge mac_clk or posedge mac_rst) begin
        if (mac_rst) begin
            state_q       <= NORMAL;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            rd_ptr_q      <= '0;
            frame_count_q <= '0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tlast_q     <= 1'b0;
            m_tvalid_q    <= 1'b0;
            drop_pulse_q  <= 1'b0;
            stat_drop_q   <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_count_q <= frame_count_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tlast_q     <= m_tlast_d;
            m_tvalid_q    <= m_tvalid_d;
            drop_pulse_q  <= drop_pulse_d;
            stat_drop_q   <= stat_drop_d;
            ready_q       <= 1'b1;
        end
    end

    assign s_axis_tready   = ready_q;
    assign m_axis_tdata    = m_tdata_q;
    assign m_axis_tkeep    = m_tkeep_q;
    assign m_axis_tlast    = m_tlast_q;
    assign m_axis_tvalid   = m_tvalid_q;
    assign frame_count     = frame_count_q;
    assign drop_pulse      = drop_pulse_q;
    assign stat_drop_count = stat_drop_q;

endmodule

// File: tb/tb_tx_axis_frame_fifo.sv
// Directed bench for tx_axis_frame_fifo (DEPTH=16) with an expected-beat queue checked at the m-side.
module tb_tx_axis_frame_fifo;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          mac_clk = 1'b0;
    logic          mac_rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [AW:0]   frame_count;
    logic          drop_pulse;
    logic [31:0]   stat_drop_count;

    int vectors = 0;
    int miscompares = 0;
    int drop_total = 0;
    logic [DW+KW:0] exp_q[$];
    logic [DW+KW:0] held;
    logic           held_v = 1'b0;

    tx_axis_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .mac_clk(mac_clk), .mac_rst(mac_rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .frame_count(frame_count), .drop_pulse(drop_pulse),
        .stat_drop_count(stat_drop_count)
    );

    always #5 mac_clk = ~mac_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // m-side monitor: pops the scoreboard on each handshake and checks that stalled beats hold.
    always @(negedge mac_clk) begin
        if (mac_rst) begin
            held_v = 1'b0;
        end else begin
            if (drop_pulse) drop_total++;
            if (held_v && m_axis_tvalid)
                chk("stall_hold", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(held));
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0)
                    chk("out_beat", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(exp_q.pop_front()));
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held   = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mac_clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit expect_out);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        if (expect_out) exp_q.push_back({l, k, d});
        @(posedge mac_clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick(1);
            i++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   fc_exp;
        bit   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        mac_rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        tick(2);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_fc", 64'(frame_count), 64'd0);
        chk("rst_stat", 64'(stat_drop_count), 64'd0);
        chk("rst_drop", 64'(drop_pulse), 64'd0);
        mac_rst = 1'b0;
        tick(2);
        chk("tready_up", 64'(s_axis_tready), 64'd1);

        // 1: single frame, sink always ready; tvalid rises two edges after tlast
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++)
            send_beat(32'h11111111 * (i + 1), (i == 3) ? 4'b0011 : 4'hF, i == 3, 1'b1);
        chk("t1_tvalid_e0", 64'(m_axis_tvalid), 64'd0);
        tick(1);
        chk("t1_tvalid_e1", 64'(m_axis_tvalid), 64'd1);
        wait_drain("t1_drain", 20);
        chk("t1_fc", 64'(frame_count), 64'd0);
        chk("t1_tvalid_end", 64'(m_axis_tvalid), 64'd0);

        // 2: same frame under a ready pattern with stalls
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_beat(32'h11111111 * (i + 1), (i == 3) ? 4'b0011 : 4'hF, i == 3, 1'b1);
        tick(2);
        chk("t2_fc1", 64'(frame_count), 64'd1);
        chk("t2_tvalid", 64'(m_axis_tvalid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            m_axis_tready = pat[i];
            tick(1);
        end
        m_axis_tready = 1'b0;
        chk("t2_fc0", 64'(frame_count), 64'd0);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        chk("t2_tvalid_end", 64'(m_axis_tvalid), 64'd0);

        // 3: oversized frame is dropped with a single pulse on beat 17
        for (int i = 0; i < 20; i++) begin
            send_beat(32'hA0000000 + i, 4'hF, i == 19, 1'b0);
            chk("t3_drop_pulse", 64'(drop_pulse), 64'(i == 16));
        end
        tick(2);
        chk("t3_stat", 64'(stat_drop_count), 64'd1);
        chk("t3_fc", 64'(frame_count), 64'd0);
        chk("t3_tvalid", 64'(m_axis_tvalid), 64'd0);
        for (int i = 0; i < 3; i++)
            send_beat(32'hA1000000 + i, 4'hF, i == 2, 1'b1);
        m_axis_tready = 1'b1;
        wait_drain("t3_drain", 20);
        chk("t3_tvalid_end", 64'(m_axis_tvalid), 64'd0);

        // 4: three buffered frames drain at one beat per cycle
        m_axis_tready = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 5; b++)
                send_beat(32'hB0000000 + f * 16 + b, 4'hF, b == 4, 1'b1);
        tick(2);
        chk("t4_fc3", 64'(frame_count), 64'd3);
        chk("t4_tvalid", 64'(m_axis_tvalid), 64'd1);
        m_axis_tready = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            tick(1);
            fc_exp = 3 - j / 5;
            chk("t4_fc", 64'(frame_count), 64'(fc_exp));
        end
        chk("t4_tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // 5: nearly full, then write and read every cycle without a drop
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++)
            send_beat(32'hC0000000 + i, 4'(i), 1'b1, 1'b1);
        chk("t5_fc16", 64'(frame_count), 64'd16);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_beat(32'hD0000000 + i, 4'hF, 1'b1, 1'b1);
            chk("t5_no_drop", 64'(drop_pulse), 64'd0);
        end
        wait_drain("t5_drain", 40);
        chk("t5_stat", 64'(stat_drop_count), 64'd1);
        chk("t5_fc", 64'(frame_count), 64'd0);
        chk("t5_drop_total", 64'(drop_total), 64'd1);

        // 6: reset in the middle of an outgoing frame
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_beat(32'hE0000000 + i, 4'hF, i == 3, 1'b1);
        tick(2);
        m_axis_tready = 1'b1;
        tick(2);
        mac_rst = 1'b1;
        #1;
        chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_fc", 64'(frame_count), 64'd0);
        chk("t6_stat", 64'(stat_drop_count), 64'd0);
        chk("t6_tready", 64'(s_axis_tready), 64'd0);
        exp_q.delete();
        tick(2);
        mac_rst = 1'b0;
        tick(2);
        chk("t6_tready_up", 64'(s_axis_tready), 64'd1);
        for (int i = 0; i < 2; i++)
            send_beat(32'hF0000000 + i, (i == 1) ? 4'b0111 : 4'hF, i == 1, 1'b1);
        wait_drain("t6_drain", 20);
        chk("t6_fc_end", 64'(frame_count), 64'd0);
        chk("t6_tvalid_end", 64'(m_axis_tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
